// File: rtl/dffram_2p.sv
// rtl/dffram_2p.sv - two-port flip-flop RAM with byte enables, optional bypass and reset clear
module dffram_2p #(
    parameter int WORDS      = 256,
    parameter int WIDTH      = 32,
    parameter int BYPASS     = 1,
    parameter int CLR_ON_RST = 1,
    localparam int NB        = WIDTH / 8,
    localparam int AW        = $clog2(WORDS * NB),
    localparam int LB        = $clog2(NB)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN0,
    input  logic [NB-1:0]    WE0,
    input  logic [AW-1:0]    A0,
    input  logic [WIDTH-1:0] Di0,
    output logic [WIDTH-1:0] Do0,
    input  logic             EN1,
    input  logic [AW-1:0]    A1,
    output logic [WIDTH-1:0] Do1,
    output logic             READY
);

    localparam int IW = AW - LB;
    localparam int CW = $clog2(WORDS);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             clr_we;
    logic [WIDTH-1:0] mem [WORDS];

    logic [IW-1:0]    idx0, idx1;
    logic [CW-1:0]    ix0, ix1;
    logic             inr0, inr1;
    logic             run, wr0;
    logic [WIDTH-1:0] old0, merged0, rd1;

    // Low address bits select a byte within the word and play no part in the access
    generate
        if (LB > 0) begin : g_lowbits
            logic unused_lowbits;
            assign unused_lowbits = ^{A0[LB-1:0], A1[LB-1:0]};
        end
    endgenerate

    assign idx0 = A0[AW-1:LB];
    assign idx1 = A1[AW-1:LB];
    assign ix0  = CW'(idx0);
    assign ix1  = CW'(idx1);
    assign inr0 = 32'(idx0) < 32'(WORDS);
    assign inr1 = 32'(idx1) < 32'(WORDS);

    assign run   = (state == RUN) && !RST;
    assign READY = (state == RUN);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_we    = 1'b0;
        if (state == CLEAR) begin
            if (CLR_ON_RST != 0) begin
                clr_we  = 1'b1;
                cnt_nxt = cnt + CW'(1);
                if (cnt == CW'(WORDS - 1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end else begin
                state_nxt = RUN;
            end
        end
    end

    assign old0 = inr0 ? mem[ix0] : '0;
    assign wr0  = run && EN0 && inr0 && (WE0 != '0);

    // Post-write value of the port 0 word, shared by the array write and the bypass path
    always_comb begin
        merged0 = old0;
        for (int i = 0; i < NB; i++) begin
            if (WE0[i]) begin
                merged0[8*i +: 8] = Di0[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd1 = inr1 ? mem[ix1] : '0;
        if ((BYPASS != 0) && wr0 && inr1 && (ix1 == ix0)) begin
            rd1 = merged0;
        end
    end

    always_ff @(posedge CLK) begin
        if (clr_we && !RST) begin
            mem[cnt] <= '0;
        end else if (wr0) begin
            mem[ix0] <= merged0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Do0 <= '0;
            Do1 <= '0;
        end else begin
            Do0 <= (run && EN0) ? old0 : '0;
            Do1 <= (run && EN1) ? rd1 : '0;
        end
    end

endmodule

// File: doc/dffram_2p.md
# dffram_2p

Parametrised flip-flop RAM with one read/write port and one read-only port, sharing a single clock.
- Adds per-byte write enables at any word width, configurable depth, and optional write-to-read bypass between ports.
- Includes a reset-triggered clear engine that zeroes every word and then raises `READY`.
- Sits behind the SoC bus adapters as tightly coupled data memory and register-file storage, replacing the fixed 32-bit single-port array.

## Interface
Parameters:
- `WORDS`, 256: number of words; any value ≥2, need not be a power of two.
- `WIDTH`, 32: word width in bits; multiple of 8. `NB = WIDTH/8` byte lanes.
- `BYPASS`, 1: 1 = port 1 sees same-cycle port 0 writes; 0 = port 1 sees old data.
- `CLR_ON_RST`, 1: 1 = zero every word after reset; 0 = contents untouched by reset.
- Derived: `AW = $clog2(WORDS*NB)` byte-address bits; `LB = $clog2(NB)` ignored low address bits.

Ports:
- `CLK`, in, 1: the single clock; all state updates on its rising edge.
- `RST`, in, 1: synchronous, active-high reset.
- `EN0`, in, 1: port 0 enable.
- `WE0`, in, NB: port 0 byte write enables; bit i covers `Di0[8i+7:8i]`.
- `A0`, in, AW: port 0 byte address.
- `Di0`, in, WIDTH: port 0 write data.
- `Do0`, out, WIDTH: port 0 registered read data.
- `EN1`, in, 1: port 1 enable.
- `A1`, in, AW: port 1 byte address.
- `Do1`, out, WIDTH: port 1 registered read data.
- `READY`, out, 1: high when the array accepts accesses.

## Operation
- Word index = `A >> LB`; the low LB address bits are ignored. An index ≥ WORDS is out of range.
- FSM states:
  - `CLEAR`: entered on any cycle with `RST`=1.
  - `RUN`: normal operation.
- In `CLEAR` with CLR_ON_RST=1:
  - A counter `cnt`, reset to 0, writes all-zero to word `cnt` each cycle and increments.
  - After writing word WORDS-1, the FSM moves to `RUN`.
- In `CLEAR` with CLR_ON_RST=0: the FSM moves to `RUN` on the first cycle with `RST`=0, with no writes.
- While not in `RUN`:
  - `EN0`, `EN1` and `WE0` are ignored.
  - `Do0` and `Do1` are loaded with 0.
- Port 0 in `RUN`, `EN0`=1:
  - `Do0` <= old word at `A0` (read-before-write).
  - Each byte lane with `WE0[i]`=1 is written from `Di0`; other lanes are preserved.
- Port 1 in `RUN`, `EN1`=1: `Do1` <= word at `A1`.
- Either port with EN=0: its `Do` is loaded with 0 on that edge.
- Out-of-range address: the read returns 0 and the write is dropped; no other word is affected.
- Collision: `EN0`=1, `WE0`≠0, `EN1`=1, same in-range word index:
  - BYPASS=1: `Do1` = old word with the written lanes replaced by `Di0` lanes, i.e. the post-write value.
  - BYPASS=0: `Do1` = old word.
- `READY` = 1 exactly when the state is `RUN` (registered output).

## Timing
- Reset values: `Do0`=0, `Do1`=0, `READY`=0, `cnt`=0, state `CLEAR`. RAM contents are not reset directly.
- Read latency: 1 cycle. Address and enable sampled at edge N; data is valid after edge N and held until the next edge.
- Write latency: 1 cycle. A write at edge N is visible to a port 1 read sampled at edge N with BYPASS=1, and to any read at edge N+1 or later.
- Clear duration, CLR_ON_RST=1:
  - `RST` deasserted before edge K, i.e. `RST`=0 is sampled at edge K.
  - Words are zeroed at edges K .. K+WORDS-1.
  - `READY`=1 after edge K+WORDS-1.
  - First accepted access is at edge K+WORDS.
- CLR_ON_RST=0: `READY`=1 after edge K; first accepted access is at edge K+1.
- Reset mid-clear: `cnt` returns to 0 and the clear restarts in full; partial progress is not resumed.
- Reset during `RUN`: any access sampled with `RST`=1 is discarded, with no write and `Do`=0.
- Throughput: one access per port per cycle; no back-pressure beyond `READY`.

## Test plan
- Clear, WORDS=16, WIDTH=32, CLR_ON_RST=1:
  - Deassert RST, then poll READY -> READY rises exactly 16 cycles later.
  - Reading all 16 words on both ports then returns 0.
- Byte writes:
  - Write 0xAABBCCDD to byte address 0x10 with WE0=4'hF, then 0x11223344 with WE0=4'b0101.
  - Read 0x10 -> Do0=0xAA22CC44 one cycle after the read is sampled.
- Collision, BYPASS=1 then BYPASS=0:
  - Word 3 holds 0x0; port 0 writes 0xFFFF0000 (WE0=4'hC) while port 1 reads word 3.
  - BYPASS=1 -> Do1=0xFFFF0000. BYPASS=0 -> Do1=0x0.
  - In both cases Do0=0x0 (read-before-write).
- Enable low and out-of-range, WORDS=12:
  - EN1=0 -> Do1=0 on the next cycle.
  - Write 0x5A5A5A5A to word index 13, then read words 0–11 and 13 -> all reads return 0.
- Reset mid-clear, WORDS=64:
  - Assert RST for 1 cycle at clear cycle 20 -> READY rises 64 cycles after the second deassertion, not 44.
  - No access is accepted before READY rises.
- WIDTH=64, CLR_ON_RST=0:
  - READY=1 one cycle after reset.
  - Write 0x0123456789ABCDEF with WE0=8'h0F to word 5, whose prior value was written as all-zero -> read returns 0x0000000089ABCDEF.
